// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide sequencer: one shift-add or shift-subtract
// step per clock over 32 cycles, result returned with a one-cycle done pulse.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpRemu  = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  cnt_q, cnt_d;
    // acc holds the product high word (multiply) or the partial remainder (divide);
    // low holds the multiplier being shifted out or the quotient being shifted in.
    logic [32:0] acc_q, acc_d;
    logic [31:0] low_q, low_d;
    logic [31:0] result_q, result_d;

    logic [32:0] mul_sum;
    logic [32:0] div_r;
    logic [32:0] div_d;
    logic [32:0] step_acc;
    logic [31:0] step_low;
    logic [31:0] final_val;

    always_comb begin
        mul_sum = {1'b0, acc_q[31:0]} + (low_q[0] ? {1'b0, opb_q} : 33'd0);
        div_r   = {acc_q[31:0], low_q[31]};
        div_d   = div_r - {1'b0, opb_q};

        if (!op_q[1]) begin
            step_acc = {1'b0, mul_sum[32:1]};
            step_low = {mul_sum[0], low_q[31:1]};
        end else if (!div_d[32]) begin
            step_acc = div_d;
            step_low = {low_q[30:0], 1'b1};
        end else begin
            step_acc = div_r;
            step_low = {low_q[30:0], 1'b0};
        end

        unique case (op_q)
            OpMul:   final_val = step_low;
            OpMulhu: final_val = step_acc[31:0];
            OpDivu:  final_val = step_low;
            OpRemu:  final_val = step_acc[31:0];
            default: final_val = step_low;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        low_d    = low_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (!flush && start) begin
                    op_d  = op;
                    opb_d = opb;
                    cnt_d = 5'd0;
                    if (op[1] && (opb == 32'd0)) begin
                        result_d = op[0] ? opa : 32'hFFFF_FFFF;
                        state_d  = StDone;
                    end else begin
                        acc_d   = 33'd0;
                        low_d   = opa;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step_acc;
                    low_d = step_low;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = final_val;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= 2'b00;
            opb_q    <= 32'd0;
            cnt_q    <= 5'd0;
            acc_q    <= 33'd0;
            low_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage and adds MUL, MULHU, DIVU and REMU to the core. It computes one shift-add or shift-subtract step per clock over 32 cycles using its own 33-bit adder/subtractor. While an operation is in flight it holds `busy` high so the control unit stalls the pipeline. It returns the result with a one-cycle `done` pulse.

## Interface
- No parameters; the datapath width is fixed at 32.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation select: 00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder).
- `opa`  in  32  multiplicand or dividend; sampled with `start`.
- `opb`  in  32  multiplier or divisor; sampled with `start`.
- `flush`  in  1  synchronous abort.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle result-valid pulse.
- `result`  out  32  registered result, held until the next completion or reset.

## Operation
- States: IDLE, RUN, DONE. `busy` = (state != IDLE). `done` = (state == DONE).
- IDLE with `start`=1:
  - Latch `op` and `opb`. Set `cnt`=0.
  - MUL/MULHU: `hi`=0, `lo`=`opa`; go to RUN.
  - DIVU/REMU with `opb`=0: set `result` to 0xFFFFFFFF (DIVU) or `opa` (REMU); go directly to DONE.
  - DIVU/REMU with `opb`≠0: `rem`=0 (33-bit), `quo`=`opa`; go to RUN.
- RUN, multiply step:
  - `sum` = {1'b0,`hi`} + ({1'b0,`opb`} if `lo`[0] else 0), 33 bits.
  - {`hi`,`lo`} <= {`sum`, `lo`[31:1]}.
- RUN, divide step:
  - `r` = {`rem`[31:0], `quo`[31]}; `d` = `r` − {1'b0,`opb`}.
  - If `d`[32]=0: `rem`<=`d` and `quo`<={`quo`[30:0],1}. Otherwise `rem`<=`r` and `quo`<={`quo`[30:0],0}.
- `cnt` increments each RUN cycle. The step performed with `cnt`=31 is the last one. On that edge, load `result` from the final value (MUL `lo`, MULHU `hi`, DIVU `quo`, REMU `rem`[31:0]) and go to DONE.
- DONE always goes to IDLE on the next edge.
- All arithmetic is unsigned and modulo 2^32 on outputs. The carry into bit 32 is kept internally only.
- `start` outside IDLE is ignored. It is not queued.
- `flush`:
  - In RUN or DONE: go to IDLE on the next edge. Suppress `done` from then on. `result` keeps its previous value.
  - `flush` has priority over `start` in IDLE; the request is dropped.
- Reset (`rst_n`=0), any time including mid-operation:
  - Immediately forces IDLE, `cnt`=0, `result`=0, internal registers 0.
  - Therefore `busy`=0 and `done`=0.

## Timing
- Let T be the edge that samples `start` in IDLE.
- Normal operation:
  - RUN during cycles T+1..T+32.
  - DONE during cycle T+33: `done`=1, `result` valid.
  - IDLE from T+34. A new `start` can be accepted on edge T+34.
  - `busy`=1 for cycles T+1..T+33.
- Divide by zero: DONE in cycle T+1 and `busy`=1 for that cycle only. Back in IDLE at T+2.
- `result` changes only on the edge entering DONE (or on reset). It is stable from the `done` cycle until the next entry to DONE.
- Outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- MUL: `opa`=7, `opb`=6 -> `done` exactly 33 cycles after `start`, `result`=42. `busy` is high for 33 cycles.
- MULHU: `opa`=`opb`=0xFFFFFFFF -> `result`=0xFFFFFFFE. A following MUL with the same operands -> `result`=0x00000001.
- DIVU then REMU: `opa`=100, `opb`=7 -> 14, then 2. Also `opa`=0xFFFFFFFF, `opb`=1 -> DIVU 0xFFFFFFFF.
- Divide by zero: DIVU with `opa`=5, `opb`=0 -> `done` at T+1 with 0xFFFFFFFF. REMU with the same operands -> `result`=5.
- Start while busy: second `start` at T+5 with different operands -> ignored; the first result is returned at T+33 and no second `done` follows.
- Abort and reset:
  - `flush` at T+10 -> IDLE at T+11, no `done`, `result` unchanged.
  - `rst_n` low at T+20 -> `busy`, `done` and `result` are 0 immediately, before the next clock edge.
  - After `rst_n` releases, a fresh MUL 3×3 -> 9.
